filter_frame_collector: RTL and testbench

FILTER_FRAME_COLLECTOR -- requirements
Module: filter_frame_collector

---
 rtl/filter_frame_collector.sv | 139 +++++++++++++
 tb/tb_filter_frame_collector.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/filter_frame_collector.sv
// Collects one frame of complex filter samples into a buffer, then drains it
// over a valid/ack port in bit-reversed (or natural) address order.
//
// state   | meaning
// IDLE    | waiting for a rising edge on in_ready
// CAPTURE | writing one sample per in_ready cycle until the buffer is full
// DRAIN   | presenting buffered samples to the consumer, one per transfer
module filter_frame_collector #(
  parameter int DEPTH  = 32,
  parameter int AW     = 5,
  parameter int BITREV = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [15:0]   in_r,
  input  logic signed [15:0]   in_i,
  input  logic                 in_ready,
  output logic signed [15:0]   dout_r,
  output logic signed [15:0]   dout_i,
  output logic                 dout_valid,
  input  logic                 dout_ack,
  output logic                 busy,
  output logic                 frame_done,
  output logic [AW-1:0]        dout_idx
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t state, next_state;

  logic signed [15:0] mem_r [DEPTH];
  logic signed [15:0] mem_i [DEPTH];

  logic          in_ready_d;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_cnt;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_next;
  logic [AW-1:0] rd_addr;
  logic          start;
  logic          wr_en;
  logic          load;
  logic          last_xfer;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = '0;
    for (int b = 0; b < AW; b++) r[b] = a[AW-1-b];
    return r;
  endfunction

  assign start   = in_ready && !in_ready_d;
  assign busy    = (state != IDLE);
  assign rd_addr = (BITREV != 0) ? bitrev(rd_next) : rd_next;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // rd_next is the count whose sample gets loaded into the output register
  // this cycle, so the read can run ahead of rd_cnt without a bubble.
  always_comb begin
    next_state = state;
    wr_en      = 1'b0;
    wr_addr    = wr_ptr;
    load       = 1'b0;
    rd_next    = rd_cnt;
    last_xfer  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          wr_en      = 1'b1;
          wr_addr    = '0;
          next_state = CAPTURE;
        end
      end
      CAPTURE: begin
        if (in_ready) begin
          wr_en = 1'b1;
          if (wr_ptr == AW'(DEPTH - 1)) begin
            next_state = DRAIN;
            rd_next    = '0;
          end
        end
      end
      DRAIN: begin
        if (!dout_valid) begin
          load = 1'b1;
        end else if (dout_ack) begin
          if (rd_cnt == AW'(DEPTH - 1)) begin
            last_xfer  = 1'b1;
            rd_next    = '0;
            next_state = IDLE;
          end else begin
            load    = 1'b1;
            rd_next = rd_cnt + 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Buffer is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem_r[wr_addr] <= in_r;
      mem_i[wr_addr] <= in_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_d <= 1'b0;
      wr_ptr     <= '0;
      rd_cnt     <= '0;
      dout_r     <= '0;
      dout_i     <= '0;
      dout_idx   <= '0;
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      in_ready_d <= in_ready;
      frame_done <= last_xfer;
      rd_cnt     <= rd_next;
      if (wr_en) wr_ptr <= wr_addr + 1'b1;
      if (load) begin
        dout_r     <= mem_r[rd_addr];
        dout_i     <= mem_i[rd_addr];
        dout_idx   <= rd_addr;
        dout_valid <= 1'b1;
      end else if (last_xfer) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_filter_frame_collector.sv
// Directed bench for filter_frame_collector: a bit-reversed and a natural-order
// instance share all inputs and are checked against hand-computed sample values.
module tb_filter_frame_collector;

  logic clk = 1'b0;
  logic reset;
  logic signed [15:0] in_r, in_i;
  logic in_ready;
  logic dout_ack;

  logic signed [15:0] b_r, b_i, n_r, n_i;
  logic b_valid, n_valid, b_busy, n_busy, b_done, n_done;
  logic [4:0] b_idx, n_idx;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  filter_frame_collector #(.DEPTH(32), .AW(5), .BITREV(1)) dut (
    .clk(clk), .reset(reset), .in_r(in_r), .in_i(in_i), .in_ready(in_ready),
    .dout_r(b_r), .dout_i(b_i), .dout_valid(b_valid), .dout_ack(dout_ack),
    .busy(b_busy), .frame_done(b_done), .dout_idx(b_idx)
  );

  filter_frame_collector #(.DEPTH(32), .AW(5), .BITREV(0)) dut_nat (
    .clk(clk), .reset(reset), .in_r(in_r), .in_i(in_i), .in_ready(in_ready),
    .dout_r(n_r), .dout_i(n_i), .dout_valid(n_valid), .dout_ack(dout_ack),
    .busy(n_busy), .frame_done(n_done), .dout_idx(n_idx)
  );

  function automatic int br5(input int k);
    int r;
    r = 0;
    for (int b = 0; b < 5; b++) if (k & (1 << b)) r |= (1 << (4 - b));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, {31'b0, b_valid}, 32'd0);
    chk({tag, "_busy"},  {31'b0, b_busy},  32'd0);
    chk({tag, "_done"},  {31'b0, b_done},  32'd0);
    chk({tag, "_r"},     {16'b0, b_r},     32'd0);
    chk({tag, "_i"},     {16'b0, b_i},     32'd0);
    chk({tag, "_idx"},   {27'b0, b_idx},   32'd0);
    chk({tag, "_nvalid"}, {31'b0, n_valid}, 32'd0);
  endtask

  // Sends n samples base+k / -(base+k); optional 3-cycle in_ready gap after sample gap_at.
  task automatic send_frame(input int base, input int n, input int gap_at);
    for (int k = 0; k < n; k++) begin
      in_ready = 1'b1;
      in_r = 16'(base + k);
      in_i = 16'(-(base + k));
      step();
      if (k == gap_at) begin
        in_ready = 1'b0;
        in_r = 16'h5555;
        in_i = 16'h5555;
        for (int g = 0; g < 3; g++) begin
          step();
          chk("gap_busy", {31'b0, b_busy}, 32'd1);
          chk("gap_valid", {31'b0, b_valid}, 32'd0);
        end
      end
    end
    if (n == 32) begin
      chk("entry_busy", {31'b0, b_busy}, 32'd1);
      chk("entry_valid", {31'b0, b_valid}, 32'd0);
    end
  endtask

  // Drains up to stop_at transfers; rnd selects 50% random ack.
  task automatic drain(input int base, input bit rnd, input int stop_at);
    int cnt, it, fd, e;
    bit xfer;
    cnt = 0; it = 0; fd = 0;
    while (cnt < stop_at && it < 400) begin
      fd += int'(b_done) + int'(n_done);
      if (b_valid) begin
        e = br5(cnt);
        chk("br_r",   {16'b0, b_r},   {16'b0, 16'(base + e)});
        chk("br_i",   {16'b0, b_i},   {16'b0, 16'(-(base + e))});
        chk("br_idx", {27'b0, b_idx}, 32'(e));
        chk("nat_valid", {31'b0, n_valid}, 32'd1);
        chk("nat_r",   {16'b0, n_r},   {16'b0, 16'(base + cnt)});
        chk("nat_i",   {16'b0, n_i},   {16'b0, 16'(-(base + cnt))});
        chk("nat_idx", {27'b0, n_idx}, 32'(cnt));
      end
      dout_ack = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      xfer = b_valid && dout_ack;
      step();
      it++;
      if (xfer) cnt++;
    end
    chk("drain_count", 32'(cnt), 32'(stop_at));
    chk("drain_no_early_done", 32'(fd), 32'd0);
    if (stop_at == 32) begin
      if (!rnd) chk("drain_cycles", 32'(it), 32'd33);
      chk("end_valid", {31'b0, b_valid}, 32'd0);
      chk("end_done",  {31'b0, b_done},  32'd1);
      chk("end_ndone", {31'b0, n_done},  32'd1);
      chk("end_busy",  {31'b0, b_busy},  32'd0);
      dout_ack = 1'b0;
      step();
      chk("done_pulse_one", {31'b0, b_done}, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; in_ready = 1'b0; in_r = '0; in_i = '0; dout_ack = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    check_reset_state("reset");

    // Scenarios 1 and 2: both orders, ack tied high
    send_frame(0, 32, -1);
    in_ready = 1'b0;
    drain(0, 1'b0, 32);

    // Scenario 3: 3-cycle stall after sample 10
    send_frame(0, 32, 10);
    in_ready = 1'b0;
    drain(0, 1'b0, 32);

    // Scenario 4: random ack
    send_frame(40, 32, -1);
    in_ready = 1'b0;
    drain(40, 1'b1, 32);

    // Scenario 5: in_ready held high through drain and beyond
    send_frame(100, 32, -1);
    in_r = 16'h7fff; in_i = 16'h7fff;
    drain(100, 1'b0, 32);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("held_high_idle", {31'b0, b_busy}, 32'd0);
    end
    in_ready = 1'b0;
    step();
    send_frame(150, 32, -1);
    in_ready = 1'b0;
    drain(150, 1'b0, 32);

    // Scenario 6: reset during capture, then during drain
    send_frame(200, 20, -1);
    reset = 1'b1;
    step();
    check_reset_state("rst_capture");
    reset = 1'b0; in_ready = 1'b0;
    step();
    chk("post_rst_idle", {31'b0, b_busy}, 32'd0);
    send_frame(250, 32, -1);
    in_ready = 1'b0;
    drain(250, 1'b0, 5);
    reset = 1'b1;
    step();
    check_reset_state("rst_drain");
    reset = 1'b0;
    // in_ready high on the first cycle after reset is a start
    send_frame(300, 32, -1);
    in_ready = 1'b0;
    drain(300, 1'b1, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
